aes128_decryptor: RTL and testbench

//   Iterative AES-128 block decryptor (FIPS-197 inverse cipher, 10 rounds).

---
 rtl/aes_pkg.sv | 113 +++++++++++
 rtl/aes128_decryptor_if.sv | 15 +
 rtl/aes_inv_round.sv | 14 +
 rtl/aes128_decryptor.sv | 91 +++++++++
 tb/tb_aes128_decryptor.sv | 130 +++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte/word helpers for the
// iterative inverse cipher.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_ADDKEY = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Byte k of the block sits at [127-8k -: 8]; row r of column c is byte 4c+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = INV_SBOX[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_decryptor_if.sv
// Block-level bus of the AES-128 decryptor: inputs, result and FSM debug view.
interface aes128_decryptor_if;
  import aes_pkg::*;

  // No ready/valid pair: ciphertext/key are sampled once in LOAD, and plaintext
  // is qualified by the level flag done, which stays high until the next reset.
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  state_t       dbg_state;

  modport master (output ciphertext, output key, input plaintext, input done, input dbg_state);
  modport slave  (input ciphertext, input key, output plaintext, output done, output dbg_state);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_last,
  output logic [127:0] o_state
);
  logic [127:0] w_keyed;

  assign w_keyed = inv_sub_bytes(inv_shift_rows(i_state)) ^ i_round_key;
  assign o_state = i_last ? w_keyed : inv_mix_columns(w_keyed);
endmodule

// File: rtl/aes128_decryptor.sv
// Iterative AES-128 decryptor: on-chip key expansion, then one inverse round
// per clock; result and sticky done flag held until the next reset.
module aes128_decryptor
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rst,
  aes128_decryptor_if.slave bus
);
  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [127:0]        r_blk;
  logic [127:0]        r_pt;
  logic                r_done;
  logic [10:0][127:0]  r_rk;
  logic [127:0]        w_rk_prev;
  logic [127:0]        w_rk_next;
  logic [31:0]         w_temp;
  logic [127:0]        w_round_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_LOAD:   w_state_nxt = ST_KEYEXP;
      ST_KEYEXP: if (r_cnt == 4'd10) w_state_nxt = ST_ADDKEY;
      ST_ADDKEY: w_state_nxt = ST_ROUND;
      ST_ROUND:  if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_DONE;
      default:   w_state_nxt = ST_LOAD;
    endcase
  end

  // r_cnt counts up through key expansion (1..10), then down through rounds (9..0).
  assign w_rk_prev = r_rk[r_cnt - 4'd1];
  assign w_temp    = sub_word(rot_word(w_rk_prev[31:0])) ^ {RCON[r_cnt], 24'h000000};
  assign w_rk_next[127:96] = w_rk_prev[127:96] ^ w_temp;
  assign w_rk_next[95:64]  = w_rk_prev[95:64]  ^ w_rk_next[127:96];
  assign w_rk_next[63:32]  = w_rk_prev[63:32]  ^ w_rk_next[95:64];
  assign w_rk_next[31:0]   = w_rk_prev[31:0]   ^ w_rk_next[63:32];

  aes_inv_round u_inv_round (
    .i_state     (r_blk),
    .i_round_key (r_rk[r_cnt]),
    .i_last      (r_cnt == 4'd0),
    .o_state     (w_round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_blk  <= '0;
      r_rk   <= '0;
      r_pt   <= '0;
      r_done <= 1'b0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          r_blk   <= bus.ciphertext;
          r_rk[0] <= bus.key;
          r_cnt   <= 4'd1;
        end
        ST_KEYEXP: begin
          r_rk[r_cnt] <= w_rk_next;
          r_cnt       <= (r_cnt == 4'd10) ? 4'd9 : r_cnt + 4'd1;
        end
        ST_ADDKEY: r_blk <= r_blk ^ r_rk[10];
        ST_ROUND: begin
          r_blk <= w_round_out;
          // Publish straight from the last round so done rises on the DONE entry edge.
          if (r_cnt == 4'd0) begin
            r_pt   <= w_round_out;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.plaintext = r_pt;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_aes128_decryptor.sv
// Directed bench for aes128_decryptor: known-answer vectors, reset abort,
// late input changes and DONE stability.
module tb_aes128_decryptor;
  import aes_pkg::*;

  localparam logic [127:0] K1  = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] C1  = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] P1  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2  = 128'h6772696666696e746772696666696e74;
  localparam logic [127:0] C2  = 128'h27a15792bba1cb6cba23475fdaa1cb1a;
  localparam logic [127:0] P2  = 128'h636f6d7061726368636f6d7061726368;
  localparam logic [127:0] K3  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C3  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P3  = 128'h00112233445566778899aabbccddeeff;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [127:0] exp_q[$];

  aes128_decryptor_if bus ();

  aes128_decryptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reset pulse, then 22 edges; scramble the inputs after edge scramble_at (0 = never).
  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] ct,
                        input int scramble_at);
    logic [127:0] exp;
    exp = exp_q.pop_front();
    @(negedge clk);
    rst = 1'b1;
    bus.key = k;
    bus.ciphertext = ct;
    @(negedge clk);
    check({tag, " rst done"}, {127'b0, bus.done}, 128'd0);
    check({tag, " rst pt"}, bus.plaintext, 128'd0);
    check({tag, " rst state"}, {125'b0, bus.dbg_state}, {125'b0, ST_LOAD});
    rst = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      #1;
      if (e == scramble_at) begin
        bus.key = rand128();
        bus.ciphertext = rand128();
      end
      if (e < 22) begin
        check($sformatf("%s early done e%0d", tag, e), {127'b0, bus.done}, 128'd0);
        check($sformatf("%s early pt e%0d", tag, e), bus.plaintext, 128'd0);
      end
    end
    check({tag, " done"}, {127'b0, bus.done}, 128'd1);
    check({tag, " pt"}, bus.plaintext, exp);
    check({tag, " state"}, {125'b0, bus.dbg_state}, {125'b0, ST_DONE});
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.key = '0;
    bus.ciphertext = '0;

    exp_q.push_back(P1);
    run_op("vec1", K1, C1, 0);
    exp_q.push_back(P2);
    run_op("vec2", K2, C2, 0);
    exp_q.push_back(P3);
    run_op("vec3", K3, C3, 0);

    // Abort in the middle of an operation, then rerun from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    bus.key = K1;
    bus.ciphertext = C1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort done", {127'b0, bus.done}, 128'd0);
    check("abort pt", bus.plaintext, 128'd0);
    check("abort state", {125'b0, bus.dbg_state}, {125'b0, ST_LOAD});
    exp_q.push_back(P1);
    run_op("vec1 rerun", K1, C1, 0);

    exp_q.push_back(P3);
    run_op("late change", K3, C3, 3);

    // Hold in DONE with the inputs wandering; result must not move.
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      bus.key = rand128();
      bus.ciphertext = rand128();
      check($sformatf("hold done c%0d", c), {127'b0, bus.done}, 128'd1);
      check($sformatf("hold pt c%0d", c), bus.plaintext, P3);
    end

    // Reset while in DONE must clear the exposed result at once.
    #1 rst = 1'b1;
    #1;
    check("done abort done", {127'b0, bus.done}, 128'd0);
    check("done abort pt", bus.plaintext, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
